cop_scheduler: RTL and testbench
================================

Name: cop_scheduler

Overview:
- Arbiter and sequencer for the shared multi-cycle coprocessor (encrypt / decrypt / FFT) on the 19-bit CPU.
- Two requesters compete for the coprocessor port:
  - requester 0: CPU execute stage.
  - requester 1: debug/DMA port.
- The block grants one request, issues it with a start pulse, waits for done or timeout, then returns the 19-bit result to the granted requester.

Parameters:
- DATA_W, 19, operand/result width.
- TIMEOUT, 64, max WAIT cycles before abort; legal range 2..255.
- ERR_DATA, 19'h7FFFF, result returned on timeout or reserved op.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid / req1_valid  input  1  request pending; held until ready.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_op / req1_op  input  2  00 ENC, 01 DEC, 10 FFT, 11 reserved.
- req0_a / req1_a, req0_b / req1_b  input  DATA_W  operands.
- rsp0_valid / rsp1_valid  output  1  one-cycle result pulse to the owning requester.
- rsp_data  output  DATA_W  result, valid with rsp*_valid.
- rsp_err  output  1  pulses with rsp*_valid on timeout or reserved op.
- cop_start  output  1  one-cycle start pulse to the coprocessor.
- cop_op  output  2  registered op.
- cop_a / cop_b  output  DATA_W  registered operands, stable from ISSUE through RESP.
- cop_done  input  1  coprocessor completion pulse.
- cop_result  input  DATA_W  valid when cop_done=1.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rr_last=1, so req0 wins the first tie.
  - All outputs 0, including cop_op/cop_a/cop_b and rsp_data.
  - Reset mid-operation aborts with no response; the coprocessor shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant rules: only one valid → it wins; both valid → the one != rr_last wins.
  - reqN_ready = (state==IDLE) & grantN, combinational; at most one ready per cycle.
  - On ready & valid:
    - latch op/a/b and owner; rr_last <= owner.
    - If op==11 → RESP with rsp_data=ERR_DATA, rsp_err=1, no cop_start.
    - Otherwise → ISSUE.
- ISSUE:
  - cop_start=1 for exactly this cycle; wait counter cleared to 0.
  - → WAIT.
  - cop_done in this cycle is ignored.
- WAIT:
  - Counter increments each cycle.
  - cop_done=1 → capture cop_result, rsp_err=0, → RESP.
  - Otherwise, if counter==TIMEOUT-1 → rsp_data=ERR_DATA, rsp_err=1, → RESP.
  - cop_done and timeout in the same cycle → done wins.
- RESP:
  - rsp{owner}_valid=1 for one cycle, with rsp_data/rsp_err; → IDLE.
  - No new grant in RESP.
  - rsp_data holds its value until the next response; rsp_err is 0 outside RESP.
- Latency:
  - Accept → cop_start: 1 cycle.
  - cop_done → rsp_valid: 1 cycle.
  - Minimum accept-to-accept: 4 cycles, with done on the first WAIT cycle.
- Requesters must not change op/a/b while valid=1 and ready=0; valid dropped before ready is legal and is treated as withdrawn.

Optional Feature:
- Macro COP_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, req0 always wins ties; rr_last still updates but is unused.
- Undefined: round-robin as described.

Test Plan:
- Single request: req0 ENC, a=19'h00123, b=19'h00045; model done 3 cycles after start with result 19'h00168 → req0_ready one cycle, cop_start next cycle, rsp0_valid one cycle after done with rsp_data=19'h00168, rsp_err=0.
- Simultaneous req0 and req1 (FFT), repeated twice after reset → grant order req0, req1, req0, req1. With COP_SCHED_FIXED_PRIO_EN → req0, req0.
- Timeout: TIMEOUT=8, model never asserts done → rsp_valid 8 cycles after cop_start, with rsp_data=19'h7FFFF and rsp_err=1; busy then falls.
- Reserved op 11 from req1 → rsp1_valid the cycle after accept, rsp_err=1, cop_start never asserted.
- Edge cases:
  - cop_done in the ISSUE cycle → ignored; a later done is honoured.
  - done coincident with the timeout cycle → rsp_err=0, real result returned.
- Reset=0 asserted during WAIT → all outputs 0 immediately, state IDLE.
  - No rsp pulse after release.
  - The next request is granted to req0 on a tie.

Source files
------------

// File: rtl/cop_scheduler.sv
// Round-robin arbiter and sequencer for the shared multi-cycle coprocessor (ENC/DEC/FFT).
// Define COP_SCHED_FIXED_PRIO_EN to make requester 0 always win ties instead of round-robin.
module cop_scheduler #(
    parameter int                 DATA_W   = 19,
    parameter int                 TIMEOUT  = 64,
    parameter logic [DATA_W-1:0]  ERR_DATA = 19'h7FFFF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,

    output logic              cop_start,
    output logic [1:0]        cop_op,
    output logic [DATA_W-1:0] cop_a,
    output logic [DATA_W-1:0] cop_b,
    input  logic              cop_done,
    input  logic [DATA_W-1:0] cop_result,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;

    logic              r_rr_last;
    logic              r_owner;
    logic              r_err;
    logic [7:0]        r_cnt;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_data;

    logic              w_idle;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_timeout;
    logic [1:0]        w_sel_op;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign w_idle = (r_state == IDLE) & reset;

`ifdef COP_SCHED_FIXED_PRIO_EN
    assign w_grant0 = req0_valid;
`else
    assign w_grant0 = req0_valid & (~req1_valid | r_rr_last);
`endif
    assign w_grant1 = req1_valid & ~w_grant0;

    assign req0_ready = w_idle & w_grant0;
    assign req1_ready = w_idle & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_sel_op = req1_ready ? req1_op : req0_op;
    assign w_sel_a  = req1_ready ? req1_a  : req0_a;
    assign w_sel_b  = req1_ready ? req1_b  : req0_b;

    // Counter reads 0 in ISSUE and k in the k-th WAIT cycle, so a timeout response lands TIMEOUT cycles after start.
    assign w_timeout = (r_state == WAIT) & (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_sel_op == OP_RSVD) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (cop_done || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= w_sel_op;
                        r_a       <= w_sel_a;
                        r_b       <= w_sel_b;
                        r_owner   <= req1_ready;
                        r_rr_last <= req1_ready;
                        r_cnt     <= '0;
                        if (w_sel_op == OP_RSVD) begin
                            r_data <= ERR_DATA;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + 8'd1;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // A completion in the timeout cycle still returns the real result.
                    if (cop_done) begin
                        r_data <= cop_result;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_data <= ERR_DATA;
                        r_err  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp0_valid = (r_state == RESP) & ~r_owner;
    assign rsp1_valid = (r_state == RESP) &  r_owner;
    assign rsp_data   = r_data;
    assign rsp_err    = (r_state == RESP) & r_err;

    assign cop_start  = (r_state == ISSUE);
    assign cop_op     = r_op;
    assign cop_a      = r_a;
    assign cop_b      = r_b;

    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cop_scheduler.sv
// Scoreboard bench for cop_scheduler: stimulus pushes expected grants/starts/responses, a monitor pops and compares.
module tb_cop_scheduler;

    localparam int DW = 19;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op = '0, req1_op = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp0_valid, rsp1_valid, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          cop_start;
    logic [1:0]    cop_op;
    logic [DW-1:0] cop_a, cop_b;
    logic          cop_done = 1'b0;
    logic [DW-1:0] cop_result = '0;
    logic          busy;

    cop_scheduler #(.DATA_W(DW), .TIMEOUT(8), .ERR_DATA(19'h7FFFF)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cop_start(cop_start), .cop_op(cop_op), .cop_a(cop_a), .cop_b(cop_b),
        .cop_done(cop_done), .cop_result(cop_result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit owner; int gap; } grant_t;
    typedef struct { logic [1:0] op; logic [DW-1:0] a; logic [DW-1:0] b; } start_t;
    typedef struct { bit owner; logic [DW-1:0] data; bit err; int lat; bit fromAccept; } rsp_t;

    grant_t grantQ[$];
    start_t startQ[$];
    rsp_t   rspQ[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastAccept = 0;
    int lastStart = 0;

    int            modelDelay = 0;
    bit            modelEarly = 1'b0;
    logic [DW-1:0] modelResult = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_cop_start", 32'(cop_start), 32'd0);
        checkOutput("rst_cop_op", 32'(cop_op), 32'd0);
        checkOutput("rst_cop_a", 32'(cop_a), 32'd0);
        checkOutput("rst_cop_b", 32'(cop_b), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic expectGrant(input bit owner, input int gap);
        grantQ.push_back('{owner: owner, gap: gap});
    endtask

    task automatic expectStart(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        startQ.push_back('{op: op, a: a, b: b});
    endtask

    task automatic expectRsp(input bit owner, input logic [DW-1:0] data, input bit err, input int lat, input bit fromAccept);
        rspQ.push_back('{owner: owner, data: data, err: err, lat: lat, fromAccept: fromAccept});
    endtask

    // Coprocessor model: optional spurious done in the ISSUE cycle, then a real done modelDelay cycles after start.
    always begin
        @(negedge clk);
        if (reset && cop_start) begin
            if (modelEarly) begin
                cop_done = 1'b1;
                cop_result = 19'h5A5A5;
                @(posedge clk); #1;
                cop_done = 1'b0;
                cop_result = '0;
            end else begin
                @(posedge clk); #1;
            end
            if (modelDelay > 0) begin
                for (int k = 1; k < modelDelay; k++) begin
                    @(posedge clk); #1;
                end
                cop_done = 1'b1;
                cop_result = modelResult;
                @(posedge clk); #1;
                cop_done = 1'b0;
                cop_result = '0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant, a start or a response.
    always @(negedge clk) begin
        if (reset) begin
            if (req0_ready || req1_ready) begin
                if (req0_ready && req1_ready) begin
                    checks++; errors++;
                    $display("[TB] FAIL dual_ready actual=11 expected=one_hot");
                end else if (grantQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_grant actual=req%0d expected=none", req1_ready);
                end else begin
                    grant_t g;
                    g = grantQ.pop_front();
                    checkOutput("grant_owner", 32'(req1_ready), 32'(g.owner));
                    if (g.gap > 0) checkOutput("accept_gap", 32'(cyc - lastAccept), 32'(g.gap));
                end
                lastAccept = cyc;
            end
            if (cop_start) begin
                if (startQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_start actual=1 expected=0");
                end else begin
                    start_t s;
                    s = startQ.pop_front();
                    checkOutput("start_op", 32'(cop_op), 32'(s.op));
                    checkOutput("start_a", 32'(cop_a), 32'(s.a));
                    checkOutput("start_b", 32'(cop_b), 32'(s.b));
                    checkOutput("start_lat", 32'(cyc - lastAccept), 32'd1);
                end
                lastStart = cyc;
            end
            if (rsp0_valid || rsp1_valid) begin
                if (rsp0_valid && rsp1_valid) begin
                    checks++; errors++;
                    $display("[TB] FAIL dual_rsp actual=11 expected=one_hot");
                end else if (rspQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_rsp actual=rsp%0d expected=none", rsp1_valid);
                end else begin
                    rsp_t r;
                    r = rspQ.pop_front();
                    checkOutput("rsp_owner", 32'(rsp1_valid), 32'(r.owner));
                    checkOutput("rsp_data", 32'(rsp_data), 32'(r.data));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(r.err));
                    checkOutput("rsp_lat", 32'(cyc - (r.fromAccept ? lastAccept : lastStart)), 32'(r.lat));
                end
            end else if (rsp_err) begin
                checks++; errors++;
                $display("[TB] FAIL rsp_err_idle actual=1 expected=0");
            end
        end
    end

    // Presents one or two requests together and holds each until its ready has been seen.
    task automatic applyStimulus(input bit v0, input logic [1:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                                 input bit v1, input logic [1:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        logic g0, g1;
        @(posedge clk); #1;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        for (int k = 0; k < 200 && (req0_valid || req1_valid); k++) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            @(posedge clk); #1;
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end
        if (req0_valid || req1_valid) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout actual=pending expected=accepted");
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkResetOutputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single ENC request, done 3 cycles after start.
        modelDelay = 3; modelEarly = 1'b0; modelResult = 19'h00168;
        expectGrant(1'b0, 0);
        expectStart(2'b00, 19'h00123, 19'h00045);
        expectRsp(1'b0, 19'h00168, 1'b0, 4, 1'b0);
        applyStimulus(1'b1, 2'b00, 19'h00123, 19'h00045, 1'b0, 2'b00, '0, '0);
        waitIdle();

        // Two tie pairs after reset: req0, req1, req0, req1 back-to-back at minimum spacing.
        doReset();
        modelDelay = 1; modelResult = 19'h2AAAA;
        expectGrant(1'b0, 0);
        expectStart(2'b00, 19'h00001, 19'h00002);
        expectRsp(1'b0, 19'h2AAAA, 1'b0, 2, 1'b0);
        expectGrant(1'b1, 4);
        expectStart(2'b10, 19'h00003, 19'h00004);
        expectRsp(1'b1, 19'h2AAAA, 1'b0, 2, 1'b0);
        applyStimulus(1'b1, 2'b00, 19'h00001, 19'h00002, 1'b1, 2'b10, 19'h00003, 19'h00004);
        waitIdle();
        modelResult = 19'h15555;
        expectGrant(1'b0, 0);
        expectStart(2'b01, 19'h00005, 19'h00006);
        expectRsp(1'b0, 19'h15555, 1'b0, 2, 1'b0);
        expectGrant(1'b1, 4);
        expectStart(2'b10, 19'h00007, 19'h00008);
        expectRsp(1'b1, 19'h15555, 1'b0, 2, 1'b0);
        applyStimulus(1'b1, 2'b01, 19'h00005, 19'h00006, 1'b1, 2'b10, 19'h00007, 19'h00008);
        waitIdle();

        // Timeout: the coprocessor never answers.
        modelDelay = 0;
        expectGrant(1'b1, 0);
        expectStart(2'b01, 19'h00011, 19'h00022);
        expectRsp(1'b1, 19'h7FFFF, 1'b1, 8, 1'b0);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b01, 19'h00011, 19'h00022);
        waitIdle();

        // Reserved op: error response the cycle after accept, no start.
        expectGrant(1'b1, 0);
        expectRsp(1'b1, 19'h7FFFF, 1'b1, 1, 1'b1);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b11, 19'h00009, 19'h00009);
        waitIdle();

        // Spurious done in the ISSUE cycle must be ignored; the later done is honoured.
        modelEarly = 1'b1; modelDelay = 3; modelResult = 19'h00777;
        expectGrant(1'b0, 0);
        expectStart(2'b00, 19'h00100, 19'h00200);
        expectRsp(1'b0, 19'h00777, 1'b0, 4, 1'b0);
        applyStimulus(1'b1, 2'b00, 19'h00100, 19'h00200, 1'b0, 2'b00, '0, '0);
        waitIdle();
        modelEarly = 1'b0;

        // Done in the same cycle as the timeout: real result wins.
        modelDelay = 7; modelResult = 19'h01234;
        expectGrant(1'b0, 0);
        expectStart(2'b10, 19'h00300, 19'h00400);
        expectRsp(1'b0, 19'h01234, 1'b0, 8, 1'b0);
        applyStimulus(1'b1, 2'b10, 19'h00300, 19'h00400, 1'b0, 2'b00, '0, '0);
        waitIdle();

        // Tie after a req0 win: round-robin favours req1, fixed priority keeps req0.
        modelDelay = 1; modelResult = 19'h0ABCD;
`ifdef COP_SCHED_FIXED_PRIO_EN
        expectGrant(1'b0, 0);
        expectStart(2'b00, 19'h00501, 19'h00502);
        expectRsp(1'b0, 19'h0ABCD, 1'b0, 2, 1'b0);
        expectGrant(1'b1, 4);
        expectStart(2'b01, 19'h00601, 19'h00602);
        expectRsp(1'b1, 19'h0ABCD, 1'b0, 2, 1'b0);
`else
        expectGrant(1'b1, 0);
        expectStart(2'b01, 19'h00601, 19'h00602);
        expectRsp(1'b1, 19'h0ABCD, 1'b0, 2, 1'b0);
        expectGrant(1'b0, 4);
        expectStart(2'b00, 19'h00501, 19'h00502);
        expectRsp(1'b0, 19'h0ABCD, 1'b0, 2, 1'b0);
`endif
        applyStimulus(1'b1, 2'b00, 19'h00501, 19'h00502, 1'b1, 2'b01, 19'h00601, 19'h00602);
        waitIdle();

        // Reset asserted during WAIT: outputs clear at once and no response follows.
        modelDelay = 0;
        expectGrant(1'b0, 0);
        expectStart(2'b01, 19'h00701, 19'h00702);
        applyStimulus(1'b1, 2'b01, 19'h00701, 19'h00702, 1'b0, 2'b00, '0, '0);
        repeat (3) @(negedge clk);
        checkOutput("busy_in_wait", 32'(busy), 32'd1);
        doReset();
        repeat (10) @(negedge clk);
        modelDelay = 1; modelResult = 19'h00042;
        expectGrant(1'b0, 0);
        expectStart(2'b00, 19'h00801, 19'h00802);
        expectRsp(1'b0, 19'h00042, 1'b0, 2, 1'b0);
        expectGrant(1'b1, 4);
        expectStart(2'b10, 19'h00901, 19'h00902);
        expectRsp(1'b1, 19'h00042, 1'b0, 2, 1'b0);
        applyStimulus(1'b1, 2'b00, 19'h00801, 19'h00802, 1'b1, 2'b10, 19'h00901, 19'h00902);
        waitIdle();

        repeat (5) @(negedge clk);
        checkOutput("grantQ_empty", 32'(grantQ.size()), 32'd0);
        checkOutput("startQ_empty", 32'(startQ.size()), 32'd0);
        checkOutput("rspQ_empty", 32'(rspQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
